// File: rtl/alu_pkg.sv
// Shared opcode encoding and opcode-class helpers for the chained ALU pipeline.
package alu_pkg;

    localparam int unsigned ALU_OP_W = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        OpAdd = 3'b000,
        OpSub = 3'b001,
        OpAnd = 3'b010,
        OpOr  = 3'b011,
        OpXor = 3'b100,
        OpNot = 3'b101,
        OpAdc = 3'b110,
        OpSbc = 3'b111
    } alu_op_t;

    function automatic logic op_is_arith(alu_op_t op);
        return (op == OpAdd) || (op == OpSub) || (op == OpAdc) || (op == OpSbc);
    endfunction

    function automatic logic op_is_sub(alu_op_t op);
        return (op == OpSub) || (op == OpSbc);
    endfunction

endpackage

// File: rtl/alu_datapath.sv
// Combinational ALU core: one shared adder for all arithmetic ops plus bitwise logic.
module alu_datapath
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [ALU_OP_W-1:0] op,
    input  logic                cin_flag,
    output logic [WIDTH-1:0]    result,
    output logic                c,
    output logic                v,
    output logic                n,
    output logic                z
);

    alu_op_t          op_e;
    logic             sub;
    logic             arith;
    logic             cin;
    logic [WIDTH-1:0] b_x;
    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] sum_low;
    logic             cout;
    logic             c_msb;

    assign op_e = alu_op_t'(op);

    always_comb begin
        sub   = op_is_sub(op_e);
        arith = op_is_arith(op_e);
        b_x   = b ^ {WIDTH{sub}};

        unique case (op_e)
            OpSub:   cin = 1'b1;
            OpAdc:   cin = cin_flag;
            OpSbc:   cin = ~cin_flag;
            default: cin = 1'b0;
        endcase

        sum_full = {1'b0, a} + {1'b0, b_x} + {{WIDTH{1'b0}}, cin};
        // Low-bit sum isolates the carry into the MSB for the overflow flag.
        sum_low  = {1'b0, a[WIDTH-2:0]} + {1'b0, b_x[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, cin};
        cout     = sum_full[WIDTH];
        c_msb    = sum_low[WIDTH-1];

        result = sum_full[WIDTH-1:0];
        unique case (op_e)
            OpAnd:   result = a & b;
            OpOr:    result = a | b;
            OpXor:   result = a ^ b;
            OpNot:   result = ~a;
            default: result = sum_full[WIDTH-1:0];
        endcase

        c = arith & (cout ^ sub);
        v = arith & (c_msb ^ cout);
        n = arith & result[WIDTH-1];
        z = (result == '0);
    end

endmodule

// File: rtl/chained_alu_pipe.sv
// Registered ALU stage with valid/ready handshake, persistent carry for ADC/SBC
// chains and a sticky overflow flag.
module chained_alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_a,
    input  logic [WIDTH-1:0]    in_b,
    input  logic [ALU_OP_W-1:0] in_op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_result,
    output logic                out_c,
    output logic                out_v,
    output logic                out_n,
    output logic                out_z,
    output logic                carry_flag,
    output logic                sticky_v,
    input  logic                clr_sticky
);

    logic [WIDTH-1:0] dp_result;
    logic             dp_c;
    logic             dp_v;
    logic             dp_n;
    logic             dp_z;
    logic             accept;
    logic             in_arith;

    logic             valid_q;
    logic [WIDTH-1:0] result_q;
    logic             c_q;
    logic             v_q;
    logic             n_q;
    logic             z_q;
    logic             carry_q;
    logic             sticky_q;

    alu_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .a        (in_a),
        .b        (in_b),
        .op       (in_op),
        .cin_flag (carry_q),
        .result   (dp_result),
        .c        (dp_c),
        .v        (dp_v),
        .n        (dp_n),
        .z        (dp_z)
    );

    // Depends only on output-side state so a held result never blocks a drain.
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign in_arith = op_is_arith(alu_op_t'(in_op));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            carry_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            if (accept) begin
                valid_q  <= 1'b1;
                result_q <= dp_result;
                c_q      <= dp_c;
                v_q      <= dp_v;
                n_q      <= dp_n;
                z_q      <= dp_z;
                if (in_arith) begin
                    carry_q <= dp_c;
                end
            end else if (valid_q && out_ready) begin
                valid_q <= 1'b0;
            end

            if (accept && dp_v) begin
                sticky_q <= 1'b1;
            end else if (clr_sticky) begin
                sticky_q <= 1'b0;
            end
        end
    end

    assign out_valid  = valid_q;
    assign out_result = result_q;
    assign out_c      = c_q;
    assign out_v      = v_q;
    assign out_n      = n_q;
    assign out_z      = z_q;
    assign carry_flag = carry_q;
    assign sticky_v   = sticky_q;

endmodule

// File: tb/tb_chained_alu_pipe.sv
// Directed bench for chained_alu_pipe: a WIDTH=16 and a WIDTH=8 instance.
module tb_chained_alu_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=16 instance
    logic        rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_a, in_b, out_result;
    logic [2:0]  in_op;
    logic        out_c, out_v, out_n, out_z, carry_flag, sticky_v, clr_sticky;

    // WIDTH=8 instance
    logic        rst8_n, iv8, ir8, ov8, or8;
    logic [7:0]  a8, b8, res8;
    logic [2:0]  op8;
    logic        c8, v8, n8, z8, cf8, sv8, clr8;

    int n_total = 0;
    int n_bad   = 0;

    chained_alu_pipe #(.WIDTH(16)) dut16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_c      (out_c),
        .out_v      (out_v),
        .out_n      (out_n),
        .out_z      (out_z),
        .carry_flag (carry_flag),
        .sticky_v   (sticky_v),
        .clr_sticky (clr_sticky)
    );

    chained_alu_pipe #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst_n      (rst8_n),
        .in_valid   (iv8),
        .in_ready   (ir8),
        .in_a       (a8),
        .in_b       (b8),
        .in_op      (op8),
        .out_valid  (ov8),
        .out_ready  (or8),
        .out_result (res8),
        .out_c      (c8),
        .out_v      (v8),
        .out_n      (n8),
        .out_z      (z8),
        .carry_flag (cf8),
        .sticky_v   (sv8),
        .clr_sticky (clr8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [15:0] res,
                           input logic c, input logic v, input logic n, input logic z);
        check({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, ".res"}, {16'b0, out_result}, {16'b0, res});
        check({tag, ".c"}, {31'b0, out_c}, {31'b0, c});
        check({tag, ".v"}, {31'b0, out_v}, {31'b0, v});
        check({tag, ".n"}, {31'b0, out_n}, {31'b0, n});
        check({tag, ".z"}, {31'b0, out_z}, {31'b0, z});
    endtask

    // One accept cycle on the 16-bit instance; checks happen #1 after the edge.
    task automatic do_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
        in_a = '0; in_b = '0; in_op = '0;
        rst8_n = 1'b0; iv8 = 1'b0; or8 = 1'b1; clr8 = 1'b0; a8 = '0; b8 = '0; op8 = '0;

        #12;
        check("rst.valid", {31'b0, out_valid}, 32'd0);
        check("rst.res", {16'b0, out_result}, 32'd0);
        check("rst.flags", {28'b0, out_c, out_v, out_n, out_z}, 32'd0);
        check("rst.carry", {31'b0, carry_flag}, 32'd0);
        check("rst.sticky", {31'b0, sticky_v}, 32'd0);
        check("rst.in_ready", {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;
        rst8_n = 1'b1;
        @(posedge clk);
        #1;

        do_op(3'b000, 16'h7FFF, 16'h0001);
        chk_out("add_ovf", 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0);
        check("add_ovf.sticky", {31'b0, sticky_v}, 32'd1);
        check("add_ovf.carry", {31'b0, carry_flag}, 32'd0);

        clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        clr_sticky = 1'b0;
        check("clr.sticky", {31'b0, sticky_v}, 32'd0);
        check("drain.valid", {31'b0, out_valid}, 32'd0);

        do_op(3'b001, 16'h0000, 16'h0001);
        chk_out("sub_borrow", 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        check("sub_borrow.carry", {31'b0, carry_flag}, 32'd1);

        do_op(3'b010, 16'hFFFF, 16'h0000);
        chk_out("and_zero", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        check("and_zero.carry", {31'b0, carry_flag}, 32'd1);

        do_op(3'b000, 16'hFFFF, 16'h0001);
        chk_out("add_wrap", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        check("add_wrap.carry", {31'b0, carry_flag}, 32'd1);

        do_op(3'b110, 16'h0000, 16'h0000);
        chk_out("adc", 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        check("adc.carry", {31'b0, carry_flag}, 32'd0);

        do_op(3'b011, 16'h0F00, 16'h00F0);
        chk_out("or", 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op(3'b100, 16'hAAAA, 16'hFFFF);
        chk_out("xor", 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op(3'b101, 16'h00FF, 16'h1234);
        chk_out("not", 16'hFF00, 1'b0, 1'b0, 1'b0, 1'b0);

        do_op(3'b001, 16'h0000, 16'h0001);
        check("pre_sbc.carry", {31'b0, carry_flag}, 32'd1);
        do_op(3'b111, 16'h0005, 16'h0002);
        chk_out("sbc", 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
        check("sbc.carry", {31'b0, carry_flag}, 32'd0);

        clr_sticky = 1'b1;
        do_op(3'b000, 16'h7FFF, 16'h0001);
        check("set_wins.sticky", {31'b0, sticky_v}, 32'd1);
        @(posedge clk);
        #1;
        clr_sticky = 1'b0;
        check("clr_alone.sticky", {31'b0, sticky_v}, 32'd0);

        // Backpressure: first op held, second op waits for the drain.
        out_ready = 1'b0;
        in_op = 3'b000; in_a = 16'h0001; in_b = 16'h0002; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_a = 16'h0004; in_b = 16'h0005;
        check("bp0.valid", {31'b0, out_valid}, 32'd1);
        check("bp0.res", {16'b0, out_result}, 32'h3);
        check("bp0.in_ready", {31'b0, in_ready}, 32'd0);
        for (int i = 1; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp%0d.res", i), {16'b0, out_result}, 32'h3);
            check($sformatf("bp%0d.in_ready", i), {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("release.in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk_out("bp_next", 16'h0009, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("bp_drain.valid", {31'b0, out_valid}, 32'd0);
        check("bp_drain.res", {16'b0, out_result}, 32'h9);

        // WIDTH=8 overflow then asynchronous reset while a result is held.
        op8 = 3'b000; a8 = 8'h80; b8 = 8'h80; iv8 = 1'b1; or8 = 1'b0;
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        check("w8.valid", {31'b0, ov8}, 32'd1);
        check("w8.res", {24'b0, res8}, 32'h0);
        check("w8.flags", {28'b0, c8, v8, n8, z8}, 32'b1101);
        check("w8.carry", {31'b0, cf8}, 32'd1);
        rst8_n = 1'b0;
        #1;
        check("w8rst.valid", {31'b0, ov8}, 32'd0);
        check("w8rst.res", {24'b0, res8}, 32'h0);
        check("w8rst.flags", {28'b0, c8, v8, n8, z8}, 32'd0);
        check("w8rst.carry_sticky", {30'b0, cf8, sv8}, 32'd0);
        check("w8rst.in_ready", {31'b0, ir8}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/chained_alu_pipe.md
# chained_alu_pipe

Parametrised, registered successor to the 16-bit structural ALU. It adds a valid/ready handshake on input and output, a one-deep output register with full-throughput backpressure, and a persistent carry/borrow flag register for multi-word add/subtract chaining (ADC/SBC). It also adds a sticky overflow flag. It sits between the operand-fetch stage and writeback, in place of the purely combinational ALU.

## Interface
- WIDTH, 16, datapath width in bits (≥ 4).
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  operands and opcode valid.
- in_ready  output  1  block can accept this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  3  opcode (alu_op_t).
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  downstream accepts the result.
- out_result  output  WIDTH  result.
- out_c, out_v, out_n, out_z  output  1 each  per-operation carry/borrow, overflow, negative, zero.
- carry_flag  output  1  persistent carry/borrow register.
- sticky_v  output  1  set by any accepted overflowing op.
- clr_sticky  input  1  synchronous clear of sticky_v.

## Operation
- Opcodes:
  - 000 ADD: A+B.
  - 001 SUB: A−B.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 NOT A.
  - 110 ADC: A+B+carry_flag.
  - 111 SBC: A−B−carry_flag.
- Adder: a single WIDTH-bit adder computes A + (B ^ {WIDTH{sub}}) + cin, with sub = op∈{SUB,SBC}.
  - cin by opcode: ADD 0, SUB 1, ADC carry_flag, SBC ~carry_flag.
  - Result is taken modulo 2^WIDTH.
- Flags for arithmetic ops:
  - C = cout ^ sub, so for SUB/SBC, C=1 means borrow.
  - V = carry into MSB ^ cout.
  - N = result[WIDTH−1].
- Flags for logical ops: C=V=N=0.
- Z = (result == 0) for every opcode.
- Accept = in_valid && in_ready. On accept:
  - out_result and out_c/v/n/z load the computed values.
  - out_valid ← 1.
  - If the op is arithmetic, carry_flag ← C. Logical ops leave carry_flag unchanged, so chains may interleave logical ops.
- carry_flag is read combinationally by the op being accepted. Back-to-back ADCs therefore chain correctly with no bubble.
- sticky_v:
  - Set on accept of an op with V=1.
  - Cleared by clr_sticky.
  - If set and clear occur in the same cycle, set wins.
- in_ready = !out_valid || out_ready, a combinational function of out_valid and out_ready only.
- If out_valid && out_ready with no accept: out_valid ← 0. Data registers hold their values.
- Output payload is stable while out_valid && !out_ready.

## Timing
- Latency 1 cycle: accepted at edge k, visible with out_valid=1 after edge k.
- Throughput: 1 op/cycle while out_ready=1.
- Reset values: out_valid=0, out_result=0, all out flags=0, carry_flag=0, sticky_v=0. in_ready=1 while in reset.
- Reset asserted mid-operation discards the held result with no partial output.
- No combinational path from in_* to out_*.

## Structure
- Package alu_pkg:
  - alu_op_t enum (3 bits, values above).
  - Helper constant localparam ALU_OP_W = 3.
- Sub-module alu_datapath (combinational, parametrised WIDTH). Inputs a, b, op, cin_flag. Outputs result, c, v, n, z.
- The top level holds the handshake, output register, carry_flag and sticky_v.

## Test plan
- WIDTH=16, ADD 0x7FFF+0x0001 → result 0x8000, c=0, v=1, n=1, z=0; sticky_v=1 next cycle.
- SUB 0x0000−0x0001 → 0xFFFF, c=1 (borrow), v=0, n=1. Then AND 0xFFFF&0x0000 → 0x0000, z=1, c=v=n=0, carry_flag still 1.
- Chaining: ADD 0xFFFF+0x0001 → 0x0000, c=1, z=1. Next cycle ADC 0x0000+0x0000 → 0x0001, carry_flag=0. SBC from carry_flag=1: 0x0005−0x0002 → 0x0002.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 after the first accept, output stable, exactly one op consumed. Release → next op accepted the same cycle the held result drains.
- clr_sticky asserted in the same cycle an overflowing op is accepted → sticky_v=1. Clear alone → 0.
- WIDTH=8, ADD 0x80+0x80 → 0x00, c=1, v=1, z=1. Assert rst_n=0 while out_valid=1 → out_valid=0 and all outputs 0 immediately.
